// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg
// Shared 7-segment constants used by the display driver and the hex counter
// blocks. Segment codes are active-low, bit order {g,f,e,d,c,b,a}. The
// package also provides the blank and anodes-off patterns and the helper that
// selects one digit's anode.
package seg_scan_driver_pkg;

  // Full 8-bit pattern {dp,g,f,e,d,c,b,a} with every segment off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Active-low anode pattern with every digit off.
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Hex glyphs, 7-bit active-low. Each is the 8-bit code with dp off, minus the dp bit.
  localparam logic [6:0] SEG7_HEX_0 = 7'h40;
  localparam logic [6:0] SEG7_HEX_1 = 7'h79;
  localparam logic [6:0] SEG7_HEX_2 = 7'h24;
  localparam logic [6:0] SEG7_HEX_3 = 7'h30;
  localparam logic [6:0] SEG7_HEX_4 = 7'h19;
  localparam logic [6:0] SEG7_HEX_5 = 7'h12;
  localparam logic [6:0] SEG7_HEX_6 = 7'h02;
  localparam logic [6:0] SEG7_HEX_7 = 7'h78;
  localparam logic [6:0] SEG7_HEX_8 = 7'h00;
  localparam logic [6:0] SEG7_HEX_9 = 7'h10;
  localparam logic [6:0] SEG7_HEX_A = 7'h08;
  localparam logic [6:0] SEG7_HEX_B = 7'h03;
  localparam logic [6:0] SEG7_HEX_C = 7'h46;
  localparam logic [6:0] SEG7_HEX_D = 7'h21;
  localparam logic [6:0] SEG7_HEX_E = 7'h06;
  localparam logic [6:0] SEG7_HEX_F = 7'h0E;

  // Active-low anode pattern that turns on only digit idx.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// hex_to_seg
// Combinational decoder from a hex nibble to a 7-segment glyph. The output is
// active-low and uses the bit order {g,f,e,d,c,b,a}.
//   nibble_i : input  [3:0] hex digit
//   seg_o    : output [6:0] active-low segment pattern
module hex_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Glyph lookup.
  always_comb begin
    seg_o = SEG7_HEX_0;
    case (nibble_i)
      4'h0:    seg_o = SEG7_HEX_0;
      4'h1:    seg_o = SEG7_HEX_1;
      4'h2:    seg_o = SEG7_HEX_2;
      4'h3:    seg_o = SEG7_HEX_3;
      4'h4:    seg_o = SEG7_HEX_4;
      4'h5:    seg_o = SEG7_HEX_5;
      4'h6:    seg_o = SEG7_HEX_6;
      4'h7:    seg_o = SEG7_HEX_7;
      4'h8:    seg_o = SEG7_HEX_8;
      4'h9:    seg_o = SEG7_HEX_9;
      4'hA:    seg_o = SEG7_HEX_A;
      4'hB:    seg_o = SEG7_HEX_B;
      4'hC:    seg_o = SEG7_HEX_C;
      4'hD:    seg_o = SEG7_HEX_D;
      4'hE:    seg_o = SEG7_HEX_E;
      4'hF:    seg_o = SEG7_HEX_F;
      default: seg_o = SEG7_HEX_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Shows a 16-bit value as four hex digits on a common-anode 7-segment
// display. The digits are multiplexed in time. The value, the decimal-point
// mask and the digit enables are captured on a load strobe into shadow
// registers. This keeps a frame from showing a mix of old and new data.
//   clk        : input        system clock, rising edge
//   reset      : input        asynchronous reset, active low
//   value      : input  [15:0] digit i = value[4i+3:4i]
//   load       : input        capture value/dp_mask/digit_en into the shadows
//   digit_en   : input  [3:0]  per-digit enable (0 = dark)
//   dp_mask    : input  [3:0]  per-digit decimal point (1 = lit)
//   blank_lz   : input        suppress leading zeros; used live, not captured
//   seg        : output [7:0]  active-low {dp,g,f,e,d,c,b,a}, registered
//   anode      : output [3:0]  active-low digit selects, registered
//   frame_tick : output       one-cycle pulse after the last digit-3 cycle
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int                 CNT_W         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST      = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam bit                 HAS_BLANK     = (BLANK_CYCLES > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       en_q, en_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       anode_q, anode_d;
  logic             tick_q, tick_d;

  logic [3:0]       cur_nib_s;
  logic [6:0]       glyph_s;
  logic [3:0]       zero_from_s;
  logic             dark_s;
  logic             slot_end_s;

  assign cur_nib_s  = shadow_q[{idx_q, 2'b00} +: 4];
  assign slot_end_s = (cnt_q == CNT_LAST);

  // zero_from_s[i] is set when nibbles i..3 of the shadow are all zero.
  assign zero_from_s[3] = (shadow_q[15:12] == 4'h0);
  assign zero_from_s[2] = zero_from_s[3] & (shadow_q[11:8] == 4'h0);
  assign zero_from_s[1] = zero_from_s[2] & (shadow_q[7:4] == 4'h0);
  assign zero_from_s[0] = zero_from_s[1] & (shadow_q[3:0] == 4'h0);

  // Digit 0 is never treated as a leading zero, so a value of zero still shows one '0'.
  assign dark_s = (HAS_BLANK && (cnt_q < CNT_BLANK_END))
               || !en_q[idx_q]
               || (blank_lz && (idx_q != 2'd0) && zero_from_s[idx_q]);

  hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nib_s),
    .seg_o    (glyph_s)
  );

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Shadow capture. A load in the same cycle as a wrap feeds the new slot directly.
  always_comb begin
    shadow_d = shadow_q;
    dp_d     = dp_q;
    en_d     = en_q;
    if (load) begin
      shadow_d = value;
      dp_d     = dp_mask;
      en_d     = digit_en;
    end else begin
      shadow_d = shadow_q;
      dp_d     = dp_q;
      en_d     = en_q;
    end
  end

  // Output pattern for the current slot. It is registered, so it lags cnt/idx by one cycle.
  always_comb begin
    seg_d   = SEG_BLANK;
    anode_d = ANODE_OFF;
    tick_d  = (idx_q == 2'd3) && slot_end_s;
    if (dark_s) begin
      seg_d   = SEG_BLANK;
      anode_d = ANODE_OFF;
    end else begin
      seg_d   = {~dp_q[idx_q], glyph_s};
      anode_d = anode_sel(idx_q);
    end
  end

  // State and output registers. Reset forces the display dark at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      dp_q     <= 4'b0000;
      en_q     <= 4'b0000;
      seg_q    <= SEG_BLANK;
      anode_q  <= ANODE_OFF;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
      anode_q  <= anode_d;
      tick_q   <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign anode      = anode_q;
  assign frame_tick = tick_q;

endmodule
